// File: rtl/cia_bus_arb.sv
// cia_bus_arb: CPU-priority two-port arbiter sharing one mos6526 register bus with a host port.
// Optional macro CIA_ARB_ICR_GUARD_EN blocks host reads of the clear-on-read ICR (rs 4'hD).
module cia_bus_arb #(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [3:0] cpu_rs,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       host_req,
  input  logic       host_rw,
  input  logic [3:0] host_rs,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_wdata,
  input  logic [7:0] cia_rdata
);

  localparam int WCW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_ACC, HOST_ACC, CAPTURE} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic           csN_q, csN_d;
  logic           rw_q, rw_d;
  logic [3:0]     rs_q, rs_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     cpuRdata_q, cpuRdata_d;
  logic [7:0]     hostRdata_q, hostRdata_d;
  logic           hostAck_q, hostAck_d;
  logic           cpuStall_q, cpuStall_d;
  logic           capHost_q, capHost_d;
  logic           capRead_q, capRead_d;
  logic           guard_q, guard_d;
  logic           guardHit;
  logic           forced;
  logic           hostGrant;
  logic           cpuGrant;

`ifdef CIA_ARB_ICR_GUARD_EN
  assign guardHit = host_rw && (host_rs == 4'hD);
`else
  assign guardHit = 1'b0;
`endif

  assign forced = (HOST_MAX_WAIT != 0) && (waitCnt_q == WAIT_MAX);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      csN_q       <= 1'b1;
      rw_q        <= 1'b1;
      rs_q        <= 4'h0;
      wdata_q     <= 8'h00;
      cpuRdata_q  <= 8'h00;
      hostRdata_q <= 8'h00;
      hostAck_q   <= 1'b0;
      cpuStall_q  <= 1'b0;
      capHost_q   <= 1'b0;
      capRead_q   <= 1'b0;
      guard_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      csN_q       <= csN_d;
      rw_q        <= rw_d;
      rs_q        <= rs_d;
      wdata_q     <= wdata_d;
      cpuRdata_q  <= cpuRdata_d;
      hostRdata_q <= hostRdata_d;
      hostAck_q   <= hostAck_d;
      cpuStall_q  <= cpuStall_d;
      capHost_q   <= capHost_d;
      capRead_q   <= capRead_d;
      guard_q     <= guard_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    csN_d       = csN_q;
    rw_d        = rw_q;
    rs_d        = rs_q;
    wdata_d     = wdata_q;
    cpuRdata_d  = cpuRdata_q;
    hostRdata_d = hostRdata_q;
    hostAck_d   = 1'b0;
    cpuStall_d  = cpuStall_q;
    capHost_d   = capHost_q;
    capRead_d   = capRead_q;
    guard_d     = guard_q;
    hostGrant   = 1'b0;
    cpuGrant    = 1'b0;

    case (state_q)
      IDLE: begin
        if (phi2_p) begin
          if (host_req && (!cpu_req || forced)) begin
            hostGrant = 1'b1;
          end else if (cpu_req) begin
            cpuGrant = 1'b1;
          end
        end
        if (hostGrant) begin
          state_d   = HOST_ACC;
          csN_d     = guardHit;
          rw_d      = host_rw;
          rs_d      = host_rs;
          wdata_d   = host_wdata;
          capHost_d = 1'b1;
          capRead_d = host_rw;
          guard_d   = guardHit;
        end else if (cpuGrant) begin
          state_d   = CPU_ACC;
          csN_d     = 1'b0;
          rw_d      = cpu_rw;
          rs_d      = cpu_rs;
          wdata_d   = cpu_wdata;
          capHost_d = 1'b0;
          capRead_d = cpu_rw;
          guard_d   = 1'b0;
        end
      end
      CPU_ACC, HOST_ACC: begin
        if (phi2_n) begin
          state_d = CAPTURE;
          csN_d   = 1'b1;
          rw_d    = 1'b1;
        end
      end
      CAPTURE: begin
        // CIA db_out is valid during this cycle, one clk after its phi2_n sample.
        state_d = IDLE;
        if (capHost_q) begin
          hostAck_d = 1'b1;
          if (capRead_q) begin
            hostRdata_d = guard_q ? 8'h00 : cia_rdata;
          end
        end else if (capRead_q) begin
          cpuRdata_d = cia_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (phi2_p) begin
      cpuStall_d = cpu_req && hostGrant;
      if (!host_req || hostGrant) begin
        waitCnt_d = '0;
      end else if (waitCnt_q != WAIT_MAX) begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
    end
  end

`ifdef CIA_ARB_ICR_GUARD_EN
  logic hostErr_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hostErr_q <= 1'b0;
    end else if (state_q == CAPTURE && capHost_q) begin
      hostErr_q <= guard_q;
    end
  end

  assign host_err = hostErr_q;
`else
  assign host_err = 1'b0;
`endif

  assign cpu_rdata  = cpuRdata_q;
  assign cpu_stall  = cpuStall_q;
  assign host_ack   = hostAck_q;
  assign host_rdata = hostRdata_q;
  assign cia_cs_n   = csN_q;
  assign cia_rw     = rw_q;
  assign cia_rs     = rs_q;
  assign cia_wdata  = wdata_q;

endmodule

// File: tb/tb_cia_bus_arb.sv
// Self-checking bench for cia_bus_arb: directed scenarios plus a randomized run against
// a phi2-cycle transaction model; a second instance checks HOST_MAX_WAIT=0.
module tb_cia_bus_arb;

  localparam int HMW = 4;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       phi2_p = 1'b0, phi2_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_rw = 1'b1;
  logic [3:0] cpu_rs = 4'h0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       host_req = 1'b0, host_rw = 1'b1;
  logic [3:0] host_rs = 4'h0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] cia_rdata = 8'h00;

  logic [7:0] cpu_rdata, host_rdata, cia_wdata;
  logic       cpu_stall, host_ack, host_err, cia_cs_n, cia_rw;
  logic [3:0] cia_rs;
  logic [7:0] cpu_rdata0, host_rdata0, cia_wdata0;
  logic       cpu_stall0, host_ack0, host_err0, cia_cs_n0, cia_rw0;
  logic [3:0] cia_rs0;

  int total = 0;
  int bad = 0;

  int         csLowCnt, ackCnt, cs0LowCnt, ack0Cnt;
  logic       rwObs, stallObs, stall0Obs, ackErr;
  logic [3:0] rsObs;
  logic [7:0] wdObs, ackRdata, cpuRdataEnd, hostRdataEnd;

`ifdef CIA_ARB_ICR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  cia_bus_arb #(.HOST_MAX_WAIT(HMW)) dut (
    .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_rw(host_rw), .host_rs(host_rs), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_wdata(cia_wdata),
    .cia_rdata(cia_rdata)
  );

  cia_bus_arb #(.HOST_MAX_WAIT(0)) dut0 (
    .clk(clk), .res_n(res_n), .phi2_p(phi2_p), .phi2_n(phi2_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
    .host_req(host_req), .host_rw(host_rw), .host_rs(host_rs), .host_wdata(host_wdata),
    .host_ack(host_ack0), .host_rdata(host_rdata0), .host_err(host_err0),
    .cia_cs_n(cia_cs_n0), .cia_rw(cia_rw0), .cia_rs(cia_rs0), .cia_wdata(cia_wdata0),
    .cia_rdata(cia_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reset asserted and released on falling edges so later stimulus stays aligned to negedge.
  task automatic doReset();
    res_n = 1'b0; phi2_p = 1'b0; phi2_n = 1'b0;
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
  endtask

  // One phi2 cycle: phi2_p now, phi2_n k clks later, then two clks for capture and ack.
  task automatic phi2Cycle(input int k);
    csLowCnt = 0; ackCnt = 0; cs0LowCnt = 0; ack0Cnt = 0;
    stall0Obs = 1'b0;
    phi2_p = 1'b1;
    for (int i = 1; i <= k + 2; i++) begin
      @(negedge clk);
      phi2_p = 1'b0;
      phi2_n = (i == k);
      if (i == 1) begin
        rwObs = cia_rw; rsObs = cia_rs; wdObs = cia_wdata; stallObs = cpu_stall;
      end
      if (!cia_cs_n) csLowCnt++;
      if (!cia_cs_n0) cs0LowCnt++;
      if (host_ack) begin
        ackCnt++; ackRdata = host_rdata; ackErr = host_err;
      end
      if (host_ack0) ack0Cnt++;
      if (cpu_stall0) stall0Obs = 1'b1;
    end
    phi2_n = 1'b0;
    cpuRdataEnd = cpu_rdata;
    hostRdataEnd = host_rdata;
  endtask

  task automatic test_reset();
    doReset();
    total++; if (cia_cs_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_cs_n got=%b exp=1", cia_cs_n); end
    total++; if (cia_rw !== 1'b1) begin bad++; $display("[TB] FAIL reset_rw got=%b exp=1", cia_rw); end
    total++; if (cia_rs !== 4'h0) begin bad++; $display("[TB] FAIL reset_rs got=%h exp=0", cia_rs); end
    total++; if (cia_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=00", cia_wdata); end
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
    total++; if (host_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_host_rdata got=%h exp=00", host_rdata); end
    total++; if ({host_ack, host_err, cpu_stall} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=000", {host_ack, host_err, cpu_stall});
    end
  endtask

  task automatic test_cpu_read();
    doReset();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_rs = 4'h4; cia_rdata = 8'h5A;
    phi2Cycle(3);
    cpu_req = 1'b0;
    total++; if (csLowCnt != 3) begin bad++; $display("[TB] FAIL cpu_read_cs_low got=%0d exp=3", csLowCnt); end
    total++; if (rsObs !== 4'h4 || rwObs !== 1'b1) begin
      bad++; $display("[TB] FAIL cpu_read_bus got rs=%h rw=%b exp rs=4 rw=1", rsObs, rwObs);
    end
    total++; if (cpuRdataEnd !== 8'h5A) begin bad++; $display("[TB] FAIL cpu_read_data got=%h exp=5a", cpuRdataEnd); end
    total++; if (stallObs !== 1'b0 || ackCnt != 0) begin
      bad++; $display("[TB] FAIL cpu_read_flags got stall=%b acks=%0d exp 0/0", stallObs, ackCnt);
    end
  endtask

  task automatic test_host_write();
    doReset();
    host_req = 1'b1; host_rw = 1'b0; host_rs = 4'h0; host_wdata = 8'h3C; cia_rdata = 8'hA5;
    phi2Cycle(2);
    host_req = 1'b0;
    total++; if (rwObs !== 1'b0 || wdObs !== 8'h3C) begin
      bad++; $display("[TB] FAIL host_write_bus got rw=%b wdata=%h exp rw=0 wdata=3c", rwObs, wdObs);
    end
    total++; if (ackCnt != 1 || ackErr !== 1'b0) begin
      bad++; $display("[TB] FAIL host_write_ack got acks=%0d err=%b exp 1/0", ackCnt, ackErr);
    end
    total++; if (hostRdataEnd !== 8'h00) begin
      bad++; $display("[TB] FAIL host_write_rdata got=%h exp=00", hostRdataEnd);
    end
  endtask

  task automatic test_starvation();
    doReset();
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_rs = 4'h1; cpu_wdata = 8'h11;
    host_req = 1'b1; host_rw = 1'b0; host_rs = 4'h2; host_wdata = 8'h22;
    for (int c = 1; c <= 6; c++) begin
      phi2Cycle(2);
      total++;
      if (c == 5) begin
        if (ackCnt != 1 || stallObs !== 1'b1 || rsObs !== 4'h2) begin
          bad++; $display("[TB] FAIL starve_cycle%0d got acks=%0d stall=%b rs=%h exp 1/1/2", c, ackCnt, stallObs, rsObs);
        end
      end else if (ackCnt != 0 || stallObs !== 1'b0 || rsObs !== 4'h1) begin
        bad++; $display("[TB] FAIL starve_cycle%0d got acks=%0d stall=%b rs=%h exp 0/0/1", c, ackCnt, stallObs, rsObs);
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_no_force();
    int acks0 = 0;
    int stalls0 = 0;
    int cpuCycles0 = 0;
    doReset();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_rs = 4'h1;
    host_req = 1'b1; host_rw = 1'b1; host_rs = 4'h2;
    for (int c = 0; c < 100; c++) begin
      phi2Cycle(2);
      acks0 += ack0Cnt;
      if (stall0Obs) stalls0++;
      if (cs0LowCnt == 2) cpuCycles0++;
    end
    cpu_req = 1'b0; host_req = 1'b0;
    total++; if (acks0 != 0) begin bad++; $display("[TB] FAIL noforce_acks got=%0d exp=0", acks0); end
    total++; if (stalls0 != 0) begin bad++; $display("[TB] FAIL noforce_stalls got=%0d exp=0", stalls0); end
    total++; if (cpuCycles0 != 100) begin bad++; $display("[TB] FAIL noforce_cpu_cycles got=%0d exp=100", cpuCycles0); end
  endtask

  task automatic test_reset_mid();
    int lateAcks = 0;
    doReset();
    host_req = 1'b1; host_rw = 1'b1; host_rs = 4'h3; cia_rdata = 8'h99;
    phi2_p = 1'b1;
    @(negedge clk);
    phi2_p = 1'b0;
    total++; if (cia_cs_n !== 1'b0) begin bad++; $display("[TB] FAIL midreset_granted got cs_n=%b exp=0", cia_cs_n); end
    res_n = 1'b0;
    #1;
    total++; if (cia_cs_n !== 1'b1) begin bad++; $display("[TB] FAIL midreset_release got cs_n=%b exp=1", cia_cs_n); end
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      phi2_n = (i == 0);
      if (host_ack) lateAcks++;
    end
    phi2_n = 1'b0;
    total++; if (lateAcks != 0) begin bad++; $display("[TB] FAIL midreset_no_ack got=%0d exp=0", lateAcks); end
    phi2Cycle(2);
    host_req = 1'b0;
    total++; if (ackCnt != 1 || ackRdata !== 8'h99) begin
      bad++; $display("[TB] FAIL midreset_retry got acks=%0d rdata=%h exp 1/99", ackCnt, ackRdata);
    end
  endtask

  task automatic test_guard();
    doReset();
    host_req = 1'b1; host_rw = 1'b1; host_rs = 4'hD; cia_rdata = 8'h77;
    phi2Cycle(3);
    host_req = 1'b0;
    total++; if (csLowCnt != (GUARD ? 0 : 3)) begin
      bad++; $display("[TB] FAIL guard_cs_low got=%0d exp=%0d", csLowCnt, GUARD ? 0 : 3);
    end
    total++; if (ackCnt != 1 || ackRdata !== (GUARD ? 8'h00 : 8'h77) || ackErr !== GUARD) begin
      bad++; $display("[TB] FAIL guard_ack got acks=%0d rdata=%h err=%b exp 1/%h/%b",
                      ackCnt, ackRdata, ackErr, GUARD ? 8'h00 : 8'h77, GUARD);
    end
  endtask

  // Transaction-level model: one grant decision per phi2 cycle, host held until its ack.
  task automatic test_random();
    bit pending = 1'b0;
    int denied = 0;
    logic [7:0] expCpu = 8'h00, expHost = 8'h00;
    doReset();
    for (int n = 0; n < 60; n++) begin
      int k;
      bit cReq, hostWins, cpuWins, guarded;
      int expCs;
      k = $urandom_range(1, 4);
      cReq = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 1) == 1) begin
        pending = 1'b1;
        host_rw = $urandom_range(0, 1);
        host_rs = ($urandom_range(0, 3) == 0) ? 4'hD : 4'($urandom_range(0, 15));
        host_wdata = 8'($urandom_range(0, 255));
      end
      cpu_req = cReq; host_req = pending;
      cpu_rw = $urandom_range(0, 1);
      cpu_rs = 4'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom_range(0, 255));
      cia_rdata = 8'($urandom_range(0, 255));

      hostWins = pending && (!cReq || (HMW > 0 && denied >= HMW));
      cpuWins = !hostWins && cReq;
      guarded = GUARD && hostWins && host_rw && (host_rs == 4'hD);
      expCs = ((hostWins && !guarded) || cpuWins) ? k : 0;
      if (cpuWins && cpu_rw) expCpu = cia_rdata;
      if (hostWins && host_rw) expHost = guarded ? 8'h00 : cia_rdata;
      denied = (pending && !hostWins) ? ((denied < HMW) ? denied + 1 : denied) : 0;

      phi2Cycle(k);

      total++; if (stallObs !== (cReq && hostWins)) begin
        bad++; $display("[TB] FAIL rand%0d_stall got=%b exp=%b", n, stallObs, cReq && hostWins);
      end
      total++; if (csLowCnt != expCs || ackCnt != (hostWins ? 1 : 0)) begin
        bad++; $display("[TB] FAIL rand%0d_grant got cs_low=%0d acks=%0d exp %0d/%0d", n, csLowCnt, ackCnt, expCs, hostWins ? 1 : 0);
      end
      total++; if (cpuRdataEnd !== expCpu || hostRdataEnd !== expHost) begin
        bad++; $display("[TB] FAIL rand%0d_rdata got cpu=%h host=%h exp %h/%h", n, cpuRdataEnd, hostRdataEnd, expCpu, expHost);
      end
      if (hostWins || cpuWins) begin
        total++; if (rsObs !== (hostWins ? host_rs : cpu_rs)) begin
          bad++; $display("[TB] FAIL rand%0d_rs got=%h exp=%h", n, rsObs, hostWins ? host_rs : cpu_rs);
        end
      end
      if (hostWins) begin
        total++; if (ackErr !== guarded) begin
          bad++; $display("[TB] FAIL rand%0d_err got=%b exp=%b", n, ackErr, guarded);
        end
        pending = 1'b0;
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_host_write();
    test_starvation();
    test_no_force();
    test_reset_mid();
    test_guard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
